// File: rtl/gl6_video_decimator_if.sv
// Video stream interface for gl6_video_decimator: an upstream pixel channel
// and a downstream pixel channel, both valid/ready with tlast (end of line)
// and tuser (start of frame) sidebands. The master side sources up_* and
// accepts down_*; the slave side is the decimator itself.
interface gl6_video_decimator_if #(
    parameter int D_WIDTH = 8
);
    logic [D_WIDTH-1:0] up_data;
    logic               up_valid;
    logic               up_tlast;
    logic               up_tuser;
    logic               up_ready;

    logic [D_WIDTH-1:0] down_data;
    logic               down_valid;
    logic               down_tlast;
    logic               down_tuser;
    logic               down_ready;

    modport master (
        output up_data, up_valid, up_tlast, up_tuser, down_ready,
        input  up_ready, down_data, down_valid, down_tlast, down_tuser
    );

    modport slave (
        input  up_data, up_valid, up_tlast, up_tuser, down_ready,
        output up_ready, down_data, down_valid, down_tlast, down_tuser
    );
endinterface

// File: rtl/gl6_video_decimator.sv
// gl6_video_decimator: drops pixels and lines of a video stream by run-time
// power-of-two factors. One pending beat is held back in H so that tlast can
// be attached to the last emitted pixel of a kept line; emitted beats go
// through a 4-entry shift FIFO whose head drives down_* directly.
// Optional build macro GL6_DECIM_AVG_EN: H accumulates the pixels of each
// horizontal group and emits their sum shifted right by the group's xs
// instead of the first pixel of the group.
module gl6_video_decimator #(
    parameter int D_WIDTH  = 8,
    parameter int MAX_LOG2 = 3,
    parameter int LW       = $clog2(MAX_LOG2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LW-1:0]        cfg_xshift,
    input  logic [LW-1:0]        cfg_yshift,
    gl6_video_decimator_if.slave vid
);
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(DEPTH);
`ifdef GL6_DECIM_AVG_EN
    localparam int AW    = D_WIDTH + MAX_LOG2;
`endif

    typedef struct packed {
        logic [D_WIDTH-1:0] data;
        logic               tlast;
        logic               tuser;
    } beat_t;

    // Out-of-range shift requests saturate at the largest supported factor.
    function automatic logic [LW-1:0] clamp_shift(input logic [LW-1:0] v);
        return (int'(v) > MAX_LOG2) ? LW'(MAX_LOG2) : v;
    endfunction

    // Counter wrap mask for a factor of 2^s.
    function automatic logic [MAX_LOG2-1:0] shift_mask(input logic [LW-1:0] s);
        return MAX_LOG2'((32'd1 << s) - 32'd1);
    endfunction

    logic [LW-1:0]       xs_q, xs_d, ys_q, ys_d;
    logic [LW-1:0]       xs_eff, ys_eff;
    logic [MAX_LOG2-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [MAX_LOG2-1:0] xc, yc;
    logic                row_kept, grp_start, beat_fire;

    logic                h_valid_q, h_valid_d;
    logic                h_tuser_q, h_tuser_d;
`ifdef GL6_DECIM_AVG_EN
    logic [AW-1:0]       h_acc_q, h_acc_d, acc_sum;
    logic [LW-1:0]       h_xs_q, h_xs_d;
`else
    logic [D_WIDTH-1:0]  h_data_q, h_data_d;
`endif
    logic [D_WIDTH-1:0]  h_hold_data, h_last_data, beat_out_data;

    beat_t               push_ent [2];
    logic [1:0]          n_push;

    beat_t               fifo_q [DEPTH];
    beat_t               fifo_d [DEPTH];
    logic [DEPTH-1:0]    fvld_q, fvld_d;
    logic [CW-1:0]       cnt_q, cnt_d, base;
    logic [SW-1:0]       slot;
    logic                pop, up_ready_w, rdy_en_q;

    assign pop        = fvld_q[0] & vid.down_ready;
    assign up_ready_w = rdy_en_q && ((cnt_q - CW'(pop)) <= CW'(DEPTH - 2));
    assign beat_fire  = vid.up_valid & up_ready_w;

    assign vid.up_ready   = up_ready_w;
    assign vid.down_valid = fvld_q[0];
    assign vid.down_data  = fifo_q[0].data;
    assign vid.down_tlast = fifo_q[0].tlast;
    assign vid.down_tuser = fifo_q[0].tuser;

    // Data values that can leave the decimator this cycle: H as it stands,
    // H completed by the current line-ending beat, or the current beat itself.
`ifdef GL6_DECIM_AVG_EN
    always_comb begin
        acc_sum       = h_acc_q + AW'(vid.up_data);
        h_hold_data   = D_WIDTH'(h_acc_q >> h_xs_q);
        h_last_data   = D_WIDTH'(acc_sum >> h_xs_q);
        beat_out_data = D_WIDTH'(AW'(vid.up_data) >> xs_eff);
    end
`else
    always_comb begin
        h_hold_data   = h_data_q;
        h_last_data   = h_data_q;
        beat_out_data = vid.up_data;
    end
`endif

    // Position tracking, keep decision, and H update for each accepted beat;
    // produces up to two beats for the output FIFO.
    always_comb begin
        xs_eff    = vid.up_tuser ? clamp_shift(cfg_xshift) : xs_q;
        ys_eff    = vid.up_tuser ? clamp_shift(cfg_yshift) : ys_q;
        xc        = vid.up_tuser ? '0 : x_cnt_q;
        yc        = vid.up_tuser ? '0 : y_cnt_q;
        row_kept  = (yc == '0);
        grp_start = row_kept && (xc == '0);

        xs_d      = xs_q;
        ys_d      = ys_q;
        x_cnt_d   = x_cnt_q;
        y_cnt_d   = y_cnt_q;
        h_valid_d = h_valid_q;
        h_tuser_d = h_tuser_q;
`ifdef GL6_DECIM_AVG_EN
        h_acc_d   = h_acc_q;
        h_xs_d    = h_xs_q;
`else
        h_data_d  = h_data_q;
`endif
        push_ent[0] = '0;
        push_ent[1] = '0;
        n_push      = 2'd0;

        if (beat_fire) begin
            xs_d    = xs_eff;
            ys_d    = ys_eff;
            x_cnt_d = vid.up_tlast ? '0 : ((xc + 1'b1) & shift_mask(xs_eff));
            y_cnt_d = vid.up_tlast ? ((yc + 1'b1) & shift_mask(ys_eff)) : yc;

            if (grp_start) begin
                if (h_valid_q) begin
                    push_ent[0] = '{data: h_hold_data, tlast: vid.up_tuser, tuser: h_tuser_q};
                    n_push      = 2'd1;
                end
                if (vid.up_tlast) begin
                    push_ent[n_push[0]] = '{data: beat_out_data, tlast: 1'b1, tuser: vid.up_tuser};
                    n_push    = n_push + 2'd1;
                    h_valid_d = 1'b0;
                end else begin
                    h_valid_d = 1'b1;
                    h_tuser_d = vid.up_tuser;
`ifdef GL6_DECIM_AVG_EN
                    h_acc_d   = AW'(vid.up_data);
                    h_xs_d    = xs_eff;
`else
                    h_data_d  = vid.up_data;
`endif
                end
            end else if (row_kept) begin
                if (vid.up_tlast) begin
                    if (h_valid_q) begin
                        push_ent[0] = '{data: h_last_data, tlast: 1'b1, tuser: h_tuser_q};
                        n_push      = 2'd1;
                    end
                    h_valid_d = 1'b0;
                end
`ifdef GL6_DECIM_AVG_EN
                else begin
                    h_acc_d = acc_sum;
                end
`endif
            end
        end
    end

    // Output FIFO: shift down on pop, then append this cycle's pushes behind
    // whatever remains so the head entry always sits in slot 0.
    always_comb begin
        fifo_d = fifo_q;
        fvld_d = fvld_q;
        slot   = '0;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_d[i] = fifo_q[i+1];
                fvld_d[i] = fvld_q[i+1];
            end
            fvld_d[DEPTH-1] = 1'b0;
        end
        base = cnt_q - CW'(pop);
        for (int k = 0; k < 2; k++) begin
            if ((k < int'(n_push)) && ((int'(base) + k) < DEPTH)) begin
                slot         = SW'(int'(base) + k);
                fifo_d[slot] = push_ent[k];
                fvld_d[slot] = 1'b1;
            end
        end
        cnt_d = base + CW'(n_push);
    end

    // Active shifts, position counters and the hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_q      <= '0;
            ys_q      <= '0;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            h_valid_q <= 1'b0;
            h_tuser_q <= 1'b0;
`ifdef GL6_DECIM_AVG_EN
            h_acc_q   <= '0;
            h_xs_q    <= '0;
`else
            h_data_q  <= '0;
`endif
        end else begin
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
            h_valid_q <= h_valid_d;
            h_tuser_q <= h_tuser_d;
`ifdef GL6_DECIM_AVG_EN
            h_acc_q   <= h_acc_d;
            h_xs_q    <= h_xs_d;
`else
            h_data_q  <= h_data_d;
`endif
        end
    end

    // FIFO storage, occupancy and per-slot valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            fvld_q <= '0;
            cnt_q  <= '0;
        end else begin
            fifo_q <= fifo_d;
            fvld_q <= fvld_d;
            cnt_q  <= cnt_d;
        end
    end

    // Input acceptance is held off until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gl6_video_decimator.sv
// Testbench for gl6_video_decimator: frames are described as rows of pixels,
// the expected output of each frame is derived row by row and group by group
// and queued when the frame is issued; a monitor pops and compares every
// beat the DUT hands downstream.
module tb_gl6_video_decimator;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          tlast;
        logic          tuser;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] cfg_xshift;
    logic [1:0] cfg_yshift;

    gl6_video_decimator_if #(.D_WIDTH(DW)) vid();

    gl6_video_decimator #(.D_WIDTH(DW), .MAX_LOG2(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_xshift (cfg_xshift),
        .cfg_yshift (cfg_yshift),
        .vid        (vid)
    );

    int            vectorCount;
    int            failCount;
    int            readyMode;
    bit            ignoreOut;
    exp_t          expQ [$];
    logic [DW-1:0] pix [8][16];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: 0 random, 1 always ready, 2 stalled.
    initial begin
        vid.down_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 0) vid.down_ready = ($urandom_range(0, 3) != 0);
            else if (readyMode == 1) vid.down_ready = 1'b1;
            else vid.down_ready = 1'b0;
        end
    end

    // Global run-time bound.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected output of one frame, derived from rows and horizontal groups.
    task automatic buildExpected(input int w, input int h, input int xs, input int ys, input int lastLen);
        int   gs;
        int   vs;
        int   len;
        int   sum;
        bit   first;
        exp_t e;
        gs    = 1 << xs;
        vs    = 1 << ys;
        first = 1'b1;
        for (int y = 0; y < h; y++) begin
            len = (y == h - 1) ? lastLen : w;
            if ((y % vs) == 0) begin
                for (int g = 0; g < len; g += gs) begin
`ifdef GL6_DECIM_AVG_EN
                    sum = 0;
                    for (int k = g; (k < g + gs) && (k < len); k++) sum += int'(pix[y][k]);
                    e.data = DW'(sum >> xs);
`else
                    sum    = int'(pix[y][g]);
                    e.data = DW'(sum);
`endif
                    e.tlast = (g + gs >= len);
                    e.tuser = first;
                    first   = 1'b0;
                    expQ.push_back(e);
                end
            end
        end
    endtask

    // Offer one beat and hold it until accepted; other beats carry random cfg.
    task automatic driveBeat(input logic [DW-1:0] d, input bit tlast, input bit tuser, input int xs, input int ys);
        int waitCount;
        vid.up_valid = 1'b1;
        vid.up_data  = d;
        vid.up_tlast = tlast;
        vid.up_tuser = tuser;
        cfg_xshift   = tuser ? 2'(xs) : 2'($urandom_range(0, 3));
        cfg_yshift   = tuser ? 2'(ys) : 2'($urandom_range(0, 3));
        waitCount    = 0;
        forever begin
            @(negedge clk);
            if (vid.up_ready) break;
            waitCount++;
            if (waitCount > 2000) begin
                checkOutput("up_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        vid.up_valid = 1'b0;
        vid.up_data  = DW'($urandom);
        cfg_xshift   = 2'($urandom_range(0, 3));
        cfg_yshift   = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one frame from pix[][]; lastLen < w leaves the last row without tlast.
    task automatic applyStimulus(input int w, input int h, input int xs, input int ys, input int lastLen);
        int len;
        buildExpected(w, h, xs, ys, lastLen);
        for (int y = 0; y < h; y++) begin
            len = (y == h - 1) ? lastLen : w;
            for (int x = 0; x < len; x++) begin
                driveBeat(pix[y][x], (x == w - 1), (x == 0 && y == 0), xs, ys);
            end
        end
    endtask

    task automatic fillRandom();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++)
                pix[y][x] = DW'($urandom);
    endtask

    task automatic drainQueue(input string name);
        int t;
        t = 0;
        while (expQ.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        checkOutput(name, 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: compares every downstream transfer and checks stall stability.
    initial begin
        exp_t        e;
        bit          holdPending;
        logic [10:0] held;
        holdPending = 1'b0;
        held        = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holdPending = 1'b0;
                continue;
            end
            if (holdPending) begin
                checkOutput("stall_stable",
                            {21'd0, vid.down_valid, vid.down_data, vid.down_tlast, vid.down_tuser},
                            {21'd0, held});
            end
            if (vid.down_valid && vid.down_ready && !ignoreOut) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", {22'd0, vid.down_data, vid.down_tlast, vid.down_tuser}, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat", {22'd0, vid.down_data, vid.down_tlast, vid.down_tuser},
                                {22'd0, e.data, e.tlast, e.tuser});
                end
            end
            holdPending = vid.down_valid && !vid.down_ready;
            held        = {vid.down_valid, vid.down_data, vid.down_tlast, vid.down_tuser};
        end
    end

    // Main sequence.
    initial begin
        int w, h, xs, ys, lastLen, nFrames;
        vectorCount  = 0;
        failCount    = 0;
        readyMode    = 1;
        ignoreOut    = 1'b0;
        rst_n        = 1'b0;
        cfg_xshift   = '0;
        cfg_yshift   = '0;
        vid.up_valid = 1'b0;
        vid.up_data  = '0;
        vid.up_tlast = 1'b0;
        vid.up_tuser = 1'b0;

        #1;
        checkOutput("reset_down_valid", 32'(vid.down_valid), 32'd0);
        checkOutput("reset_down_data",  32'(vid.down_data),  32'd0);
        checkOutput("reset_down_tlast", 32'(vid.down_tlast), 32'd0);
        checkOutput("reset_down_tuser", 32'(vid.down_tuser), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("up_ready_after_reset", 32'(vid.up_ready), 32'd1);

        $display("[TB] xs=1 ys=1 8x4 ramp frame");
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                pix[y][x] = DW'(x + 16 * y);
        applyStimulus(8, 4, 1, 1, 8);
        drainQueue("drain_ramp");

        $display("[TB] xs=0 ys=0 4x2 passthrough, random ready");
        readyMode = 0;
        fillRandom();
        applyStimulus(4, 2, 0, 0, 4);
        drainQueue("drain_passthrough");

        $display("[TB] xs=2 partial group, line length 6");
        fillRandom();
        applyStimulus(6, 2, 2, 0, 6);
        drainQueue("drain_partial");

        $display("[TB] downstream stall mid-line");
        readyMode = 1;
        fillRandom();
        fork
            applyStimulus(16, 2, 0, 0, 16);
            begin
                repeat (6) @(posedge clk);
                readyMode = 2;
                repeat (20) @(posedge clk);
                #2;
                checkOutput("stall_up_ready", 32'(vid.up_ready), 32'd0);
                checkOutput("stall_down_valid", 32'(vid.down_valid), 32'd1);
                readyMode = 1;
            end
        join
        drainQueue("drain_stall");

        $display("[TB] truncated line followed by a new frame");
        readyMode = 0;
        fillRandom();
        applyStimulus(8, 2, 1, 0, 5);
        fillRandom();
        applyStimulus(8, 2, 2, 0, 8);
        drainQueue("drain_truncated");

        $display("[TB] xs=2 group 10,20,30,41");
        pix[0][0] = 8'd10;
        pix[0][1] = 8'd20;
        pix[0][2] = 8'd30;
        pix[0][3] = 8'd41;
        applyStimulus(4, 1, 2, 0, 4);
        drainQueue("drain_group");

        $display("[TB] reset mid-line");
        readyMode = 1;
        ignoreOut = 1'b1;
        fillRandom();
        driveBeat(pix[0][0], 1'b0, 1'b1, 0, 0);
        for (int x = 1; x < 5; x++) driveBeat(pix[0][x], 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_down_valid", 32'(vid.down_valid), 32'd0);
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("up_ready_after_midreset", 32'(vid.up_ready), 32'd1);
        ignoreOut = 1'b0;
        fillRandom();
        applyStimulus(6, 3, 1, 1, 6);
        drainQueue("drain_after_reset");

        $display("[TB] random frames");
        readyMode = 0;
        nFrames   = 24;
        for (int f = 0; f < nFrames; f++) begin
            w  = $urandom_range(1, 12);
            h  = $urandom_range(1, 6);
            xs = $urandom_range(0, 3);
            ys = $urandom_range(0, 3);
            lastLen = w;
            if ((f < nFrames - 1) && (w > 1) && ($urandom_range(0, 3) == 0))
                lastLen = $urandom_range(1, w - 1);
            fillRandom();
            applyStimulus(w, h, xs, ys, lastLen);
        end
        readyMode = 1;
        drainQueue("drain_final");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_idle", 32'(vid.down_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end
endmodule

// File: doc/gl6_video_decimator.md
Name: gl6_video_decimator

Overview:
- Parametrised successor to the fixed 2x2 stream queue: drops pixels and lines of an AXI-Stream-style video stream by run-time power-of-two factors (1..2^MAX_LOG2 per axis).
- Generates correct down_tlast on the last emitted pixel of each kept line, and down_tuser on the first emitted pixel of each frame.
- Sits between the pixel source and the downstream scaler/packer.
- Buffered output with a full-throughput handshake.

Parameters:
- D_WIDTH, 8: pixel data width.
- MAX_LOG2, 3: maximum log2 decimation factor per axis.
- LW, $clog2(MAX_LOG2+1): width of shift config ports (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_xshift  in  LW  log2 horizontal factor; values >MAX_LOG2 clamp to MAX_LOG2.
- cfg_yshift  in  LW  log2 vertical factor; same clamping.
- up_data  in  D_WIDTH  input pixel.
- up_valid  in  1  input beat valid.
- up_tlast  in  1  last pixel of line.
- up_tuser  in  1  first pixel of frame.
- up_ready  out  1  input accepted when up_valid & up_ready.
- down_data  out  D_WIDTH  output pixel.
- down_valid  out  1  output beat valid.
- down_tlast  out  1  last output pixel of line.
- down_tuser  out  1  first output pixel of frame.
- down_ready  in  1  downstream accept.

Behaviour:
- Reset (async, rst_n=0):
  - down_valid/down_data/down_tlast/down_tuser = 0.
  - Output FIFO empty; hold register H invalid.
  - Counters x_cnt = y_cnt = 0.
  - Active shifts xs = ys = 0 (passthrough).
  - up_ready = 1 one cycle after release.
  - Reset mid-frame discards everything in flight.
- Config:
  - xs/ys load from the clamped cfg_* on each accepted beat with up_tuser=1.
  - The new values apply to that beat.
  - Changes to cfg_* at any other time are ignored.
- Counters (update per accepted beat):
  - up_tuser: x_cnt=0, y_cnt=0 for this beat.
  - x_cnt increments modulo 2^xs; on up_tlast it resets to 0 for the next beat.
  - y_cnt increments modulo 2^ys on each up_tlast beat.
- Keep rule:
  - A row is kept iff y_cnt==0.
  - A pixel starts a group iff the row is kept and x_cnt==0.
  - Beats in discarded rows produce no output, including their tlast.
- Hold register H (one pending output beat, to resolve tlast):
  - Group-start beat, no tlast: push H (tlast=0) if valid; H<=beat.
  - Non-start beat in kept row with tlast: push H with tlast=1; H invalid.
  - Group-start beat with tlast: push H (tlast=0) if valid, then push beat (tlast=1). Two pushes in one cycle.
  - up_tuser beat while H valid (truncated line): push H with tlast=1 first, then the beat enters H.
  - H.tuser is set when H was loaded from a tuser beat.
- Output FIFO:
  - Depth 4, registered outputs; down_* driven from the head entry.
  - up_ready = (free entries >= 2) after this cycle's pop.
  - down_* hold stable while down_valid & ~down_ready.
  - Latency: a kept pixel appears on down_* at the earliest 1 cycle after the next kept/tlast beat is accepted.
  - FIFO never overflows. When full, no push occurs because up_ready=0.
- xs=ys=0: every beat is output 1:1 with identical tlast/tuser. Each beat is emitted 1 cycle after the following beat, or after its own tlast beat.
- Width: x_cnt/y_cnt are MAX_LOG2 bits; masking is by (1<<xs)-1.

Optional Feature:
- Macro: GL6_DECIM_AVG_EN.
- Defined: H carries accumulator acc (D_WIDTH+MAX_LOG2 bits).
  - Group start: acc=up_data.
  - Each further beat of the group in a kept row: acc+=up_data.
  - Emitted data = acc >> xs(H), truncated, using the xs captured with H.
  - A partial group at line end is still shifted by the full xs (edge darkening accepted).
  - Vertical axis is not averaged.
- Undefined: emitted data = first pixel of the group; no accumulator logic.

Test Plan:
- xs=1, ys=1, 8x4 frame, data=x+16*y, down_ready=1 -> output rows y=0,2 with data 0,2,4,6 / 32,34,36,38; tlast on 6 and 38; tuser on 0 only.
- xs=0, ys=0, 4x2 frame, random down_ready -> output identical to input incl. tlast/tuser; no beat lost or duplicated.
- xs=2, ys=0, line length 6 (partial group) -> 2 outputs per line (x=0, x=4), tlast on x=4 output.
- down_ready=0 for 20 cycles mid-line, xs=ys=0 -> up_ready drops after 2-3 accepted beats; down_* stable; recovery loses nothing.
- cfg_xshift changed mid-frame, then new tuser arriving before previous tlast -> old config kept until tuser; pending H emitted with tlast=1 ahead of new frame's tuser beat.
- GL6_DECIM_AVG_EN, xs=2, pixels 10,20,30,41 -> output 25; rst_n pulsed mid-line -> down_valid=0 immediately, first post-reset tuser frame correct.
